// File: rtl/fifo_stream_reader.sv
// Read-side adapter: FIFO pop interface -> valid/ready stream, with credit-based reads.
// Optional word_count output and counter enabled by defining READER_COUNT_EN.
module fifo_stream_reader #(
    parameter int WIDTH       = 8,
    parameter int RD_LATENCY  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef READER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] word_count
`endif
);

    localparam int DEPTH = RD_LATENCY + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("fifo_stream_reader: RD_LATENCY must be 1 or 2");
        end
        if (COUNT_WIDTH < 1) begin : g_bad_count
            $error("fifo_stream_reader: COUNT_WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0]      slots [DEPTH];
    logic [PW-1:0]         head, tail;
    logic [OW-1:0]         occ;
    logic [RD_LATENCY-1:0] pend, pend_nxt;
    logic [OW-1:0]         inflight;
    logic                  capture, xfer;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + OW'(pend[i]);
    end

    // Every issued read owns a slot until it is delivered, so captures never overflow.
    assign fifo_rd   = !rst && !fifo_empty &&
                       (({1'b0, occ} + {1'b0, inflight}) < (OW + 1)'(DEPTH));
    assign capture   = pend[0];
    assign out_valid = (occ != '0);
    assign out_data  = slots[head];
    assign xfer      = out_valid && out_ready;

    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < RD_LATENCY - 1; i++)
            pend_nxt[i] = pend[i + 1];
        pend_nxt[RD_LATENCY-1] = fifo_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            pend <= '0;
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            pend <= pend_nxt;
            if (capture) begin
                slots[tail] <= fifo_data;
                tail        <= bump(tail);
            end
            if (xfer)
                head <= bump(head);
            case ({capture, xfer})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef READER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            word_count <= '0;
        else if (xfer)
            word_count <= word_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (read latency 1 and 2) fed by FIFO models,
// outputs checked against a pop-order scoreboard.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty1, rd1, valid1, ready1;
    logic [7:0] data1, odata1;
    logic       empty2, rd2, valid2, ready2;
    logic [7:0] data2, odata2;
`ifdef READER_COUNT_EN
    logic [3:0] cnt1, cnt2;
`endif

    int checks = 0;
    int failures = 0;

    // FIFO models: write pointer owned by tasks, read pointer by the pop responder.
    logic [7:0] mem1 [0:4095];
    logic [7:0] mem2 [0:4095];
    int  wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
    bit  hold1 = 0, hold2 = 0;
    logic [7:0] stage2;
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];

    assign empty1 = hold1 || (wp1 == rp1);
    assign empty2 = hold2 || (wp2 == rp2);

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .RD_LATENCY(1), .COUNT_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_rd(rd1), .fifo_data(data1),
        .out_valid(valid1), .out_ready(ready1), .out_data(odata1)
`ifdef READER_COUNT_EN
        , .word_count(cnt1)
`endif
    );

    fifo_stream_reader #(.WIDTH(8), .RD_LATENCY(2), .COUNT_WIDTH(4)) u2 (
        .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_rd(rd2), .fifo_data(data2),
        .out_valid(valid2), .out_ready(ready2), .out_data(odata2)
`ifdef READER_COUNT_EN
        , .word_count(cnt2)
`endif
    );

    // Read data appears RD_LATENCY cycles after the pop; garbage otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rp1 <= 0; data1 <= 8'h00;
            rp2 <= 0; stage2 <= 8'h00; data2 <= 8'h00;
        end else begin
            if (rd1) begin data1 <= mem1[rp1]; rp1 <= rp1 + 1; end
            else data1 <= 8'($urandom);
            if (rd2) begin stage2 <= mem2[rp2]; rp2 <= rp2 + 1; end
            else stage2 <= 8'($urandom);
            data2 <= stage2;
        end
    end

    task automatic push1(input logic [7:0] v);
        mem1[wp1] = v; wp1++; exp1.push_back(v);
    endtask

    task automatic push2(input logic [7:0] v);
        mem2[wp2] = v; wp2++; exp2.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ready1 = 1'b0; ready2 = 1'b0; hold1 = 0; hold2 = 0;
        wp1 = 0; wp2 = 0; exp1.delete(); exp2.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ready1 = 1'b0; ready2 = 1'b0;
        #1;
        checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b exp=0", valid1); end
        checks++; if (rd1 !== 1'b0) begin failures++; $display("FAIL reset_rd1 got=%b exp=0", rd1); end
        checks++; if (odata1 !== 8'h00) begin failures++; $display("FAIL reset_data1 got=%h exp=00", odata1); end
        checks++; if (valid2 !== 1'b0) begin failures++; $display("FAIL reset_valid2 got=%b exp=0", valid2); end
        checks++; if (odata2 !== 8'h00) begin failures++; $display("FAIL reset_data2 got=%h exp=00", odata2); end
`ifdef READER_COUNT_EN
        checks++; if (cnt1 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_empty_boundary();
        int rdc = 0, xf = 0;
        do_reset();
        ready1 = 1'b1;
        push1(8'h5A);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rd1) rdc++;
            if (valid1 && ready1) begin
                xf++;
                checks++; if (exp1.size() == 0 || odata1 !== exp1[0]) begin failures++; $display("FAIL empty_data got=%h exp=5a", odata1); end
                if (exp1.size() != 0) void'(exp1.pop_front());
            end
            @(negedge clk);
        end
        #1;
        checks++; if (rdc != 1) begin failures++; $display("FAIL empty_rd_pulses got=%0d exp=1", rdc); end
        checks++; if (xf != 1) begin failures++; $display("FAIL empty_transfers got=%0d exp=1", xf); end
        checks++; if (valid1 !== 1'b0 || rd1 !== 1'b0) begin failures++; $display("FAIL empty_idle got valid=%b rd=%b exp 0/0", valid1, rd1); end
    endtask

    task automatic test_throughput();
        int first = -1;
        do_reset();
        ready1 = 1'b1;
        for (int i = 1; i <= 32; i++) push1(8'(i));
        #1;
        checks++; if (rd1 !== 1'b1) begin failures++; $display("FAIL tput_first_rd got=%b exp=1", rd1); end
        for (int c = 1; c <= 10 && first < 0; c++) begin
            @(negedge clk); #1;
            if (valid1) first = c;
        end
        checks++; if (first != 2) begin failures++; $display("FAIL tput_latency got=%0d exp=2", first); end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (valid1 !== 1'b1 || odata1 !== 8'(k + 1)) begin
                failures++; $display("FAIL tput_word%0d got valid=%b data=%h exp 1/%h", k, valid1, odata1, 8'(k + 1));
            end
            @(negedge clk); #1;
        end
        exp1.delete();
        checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL tput_drained got=%b exp=0", valid1); end
    endtask

    task automatic test_backpressure();
        int rdc = 0, got = 0;
        logic [7:0] head;
        do_reset();
        ready2 = 1'b0;
        for (int i = 0; i < 8; i++) push2(8'($urandom));
        head = exp2[0];
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rd2) rdc++;
            @(negedge clk);
        end
        #1;
        checks++; if (rdc != 4) begin failures++; $display("FAIL bp_rd_pulses got=%0d exp=4", rdc); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd2 !== 1'b0 || valid2 !== 1'b1 || odata2 !== head) begin
                failures++; $display("FAIL bp_hold got rd=%b valid=%b data=%h exp 0/1/%h", rd2, valid2, odata2, head);
            end
            @(negedge clk); #1;
        end
        ready2 = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            #1;
            if (valid2 && ready2) begin
                got++;
                checks++; if (exp2.size() == 0 || odata2 !== exp2[0]) begin failures++; $display("FAIL bp_drain_order got=%h", odata2); end
                if (exp2.size() != 0) void'(exp2.pop_front());
            end
            @(negedge clk);
        end
        #1;
        checks++; if (got != 8) begin failures++; $display("FAIL bp_drain_count got=%0d exp=8", got); end
        checks++; if (valid2 !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", valid2); end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        bit seen = 0;
        do_reset();
        ready1 = 1'b1;
        push1(8'd10); push1(8'd11); push1(8'd12);
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (valid1 && ready1) begin
                seen = 1;
                checks++; if (odata1 !== 8'd10) begin failures++; $display("FAIL rmid_first got=%h exp=0a", odata1); end
            end else @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rmid_timeout got=none exp=transfer"); end
        @(posedge clk); #2;
        rst = 1'b1; wp1 = 0; exp1.delete();
        #1;
        checks++; if (valid1 !== 1'b0 || rd1 !== 1'b0) begin failures++; $display("FAIL rmid_reset got valid=%b rd=%b exp 0/0", valid1, rd1); end
        @(negedge clk);
        rst = 1'b0;
        push1(8'd20); push1(8'd21);
        for (int c = 0; c < 15; c++) begin
            #1;
            if (valid1 && ready1) begin
                got++;
                checks++; if (exp1.size() == 0 || odata1 !== exp1[0]) begin failures++; $display("FAIL rmid_word got=%h", odata1); end
                if (exp1.size() != 0) void'(exp1.pop_front());
            end
            @(negedge clk);
        end
        checks++; if (got != 2) begin failures++; $display("FAIL rmid_count got=%0d exp=2", got); end
    endtask

    task automatic test_random();
        int sent1 = 0, sent2 = 0, got1 = 0, got2 = 0, rdc1 = 0, rdc2 = 0;
        do_reset();
        for (int cyc = 0; cyc < 20000 && (got1 < 1000 || got2 < 1000); cyc++) begin
            if (sent1 < 1000 && $urandom_range(0, 1) == 1) begin push1(8'($urandom)); sent1++; end
            if (sent2 < 1000 && $urandom_range(0, 1) == 1) begin push2(8'($urandom)); sent2++; end
            if (sent1 == 1000) hold1 = 0; else if ($urandom_range(0, 7) == 0) hold1 = !hold1;
            if (sent2 == 1000) hold2 = 0; else if ($urandom_range(0, 7) == 0) hold2 = !hold2;
            ready1 = 1'($urandom_range(0, 1));
            ready2 = 1'($urandom_range(0, 1));
            #1;
            if (valid1 && ready1) begin
                got1++;
                checks++; if (exp1.size() == 0 || odata1 !== exp1[0]) begin failures++; $display("FAIL rand1_word%0d got=%h", got1, odata1); end
                if (exp1.size() != 0) void'(exp1.pop_front());
            end
            if (valid2 && ready2) begin
                got2++;
                checks++; if (exp2.size() == 0 || odata2 !== exp2[0]) begin failures++; $display("FAIL rand2_word%0d got=%h", got2, odata2); end
                if (exp2.size() != 0) void'(exp2.pop_front());
            end
            if (rd1) begin
                rdc1++;
                checks++; if (rdc1 - got1 > 3) begin failures++; $display("FAIL rand1_credit got=%0d exp<=3", rdc1 - got1); end
            end
            if (rd2) begin
                rdc2++;
                checks++; if (rdc2 - got2 > 4) begin failures++; $display("FAIL rand2_credit got=%0d exp<=4", rdc2 - got2); end
            end
            @(negedge clk);
        end
        checks++; if (got1 != 1000) begin failures++; $display("FAIL rand1_total got=%0d exp=1000", got1); end
        checks++; if (got2 != 1000) begin failures++; $display("FAIL rand2_total got=%0d exp=1000", got2); end
    endtask

`ifdef READER_COUNT_EN
    task automatic test_word_count();
        int xf = 0;
        do_reset();
        ready1 = 1'b1;
        for (int i = 0; i < 17; i++) push1(8'($urandom));
        for (int c = 0; c < 30; c++) begin
            #1;
            checks++; if (cnt1 !== 4'(xf)) begin failures++; $display("FAIL count got=%0d exp=%0d", cnt1, 4'(xf)); end
            if (valid1 && ready1) begin xf++; void'(exp1.pop_front()); end
            @(negedge clk);
        end
        checks++; if (xf != 17) begin failures++; $display("FAIL count_transfers got=%0d exp=17", xf); end
    endtask
`endif

    initial begin
        ready1 = 1'b0; ready2 = 1'b0;
        test_reset();
        test_empty_boundary();
        test_throughput();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef READER_COUNT_EN
        test_word_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
